// File: rtl/urv_fetch_pkg.sv
// Shared fetch-stage types and constants for the uRV core.
// Holds the reset vector default, the fetch word layout and PC stepping.
package urv_fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] URV_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] INSN_BYTES   = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] pc;
    } fetch_word_t;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + INSN_BYTES;
    endfunction

endpackage

// File: rtl/urv_fetch.sv
// uRV fetch: owns the PC, keeps one memory request outstanding; request->f_valid_o is 2 cycles.
// Decode stall holds f_*_o; a response landing during stall parks in a one-entry skid.
module urv_fetch
    import urv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = URV_RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        f_stall_i,
    input  logic        x_bra_i,
    input  logic [31:0] x_pc_bra_i,
    output logic [31:0] im_addr_o,
    output logic        im_rd_o,
    input  logic [31:0] im_data_i,
    input  logic        im_valid_i,
    output logic [31:0] f_ir_o,
    output logic [31:0] f_pc_o,
    output logic        f_valid_o
);

    logic [31:0] r_pc;
    logic        r_inflight;
    logic [31:0] r_inflight_pc;
    logic        r_discard;
    logic        r_skid_valid;
    fetch_word_t r_skid;
    fetch_word_t r_out;
    logic        r_f_valid;

    logic        w_resp;
    logic        w_keep;
    logic        w_can_issue;
    logic        w_issue;
    logic [31:0] w_addr;

    always_comb begin
        w_resp      = r_inflight && im_valid_i;
        w_keep      = w_resp && !r_discard;
        w_can_issue = !r_skid_valid && (!r_inflight || w_resp);
        w_issue     = !rst_i && w_can_issue && (!f_stall_i || x_bra_i);
        w_addr      = x_bra_i ? x_pc_bra_i : r_pc;
    end

    assign im_rd_o   = w_issue;
    assign im_addr_o = w_addr;
    assign f_ir_o    = r_out.ir;
    assign f_pc_o    = r_out.pc;
    assign f_valid_o = r_f_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_discard     <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_skid        <= '0;
            r_out         <= '0;
            r_f_valid     <= 1'b0;
        end else begin
            if (w_issue) begin
                r_pc          <= next_pc(w_addr);
                r_inflight    <= 1'b1;
                r_inflight_pc <= w_addr;
            end else begin
                // A redirect that cannot issue yet still retargets the PC.
                if (x_bra_i) begin
                    r_pc <= x_pc_bra_i;
                end
                if (w_resp) begin
                    r_inflight <= 1'b0;
                end
            end

            if (w_resp) begin
                r_discard <= 1'b0;
            end else if (x_bra_i && r_inflight) begin
                r_discard <= 1'b1;
            end

            if (x_bra_i) begin
                r_f_valid    <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (f_stall_i) begin
                if (w_keep) begin
                    r_skid_valid <= 1'b1;
                    r_skid       <= '{ir: im_data_i, pc: r_inflight_pc};
                end
            end else if (w_keep) begin
                r_out     <= '{ir: im_data_i, pc: r_inflight_pc};
                r_f_valid <= 1'b1;
            end else if (r_skid_valid) begin
                r_out        <= r_skid;
                r_f_valid    <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_f_valid <= 1'b0;
            end
        end
    end

endmodule
